// File: rtl/dev_i2c_phy_bit.sv
// Bit-level I2C master PHY: runs START/STOP/WRITE/READ as four quarter-bit phases off the scaler tick.
// Optional clock stretching support is enabled by defining DEV_I2C_PHY_STRETCH_EN.
module dev_i2c_phy_bit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd,
  input  logic       i_cmd_bit,
  output logic       o_rsp_valid,
  output logic       o_rsp_bit,
  output logic       o_rsp_arb,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t     state, state_nxt;
  logic [1:0] cmd, cmd_nxt;
  logic       wbit, wbit_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, adv;
  logic       scl_oe_nxt, sda_oe_nxt;
  logic       rsp_valid_nxt, rsp_bit_nxt, rsp_arb_nxt;

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];

  // (scl_oe, sda_oe) for a given command and phase
  function automatic logic [1:0] drive(input logic [1:0] c, input logic b, input state_t p);
    case (c)
      CMD_START: case (p)
        P0:      return 2'b00;
        P1, P2:  return 2'b01;
        default: return 2'b11;
      endcase
      CMD_STOP: case (p)
        P0:      return 2'b11;
        P1, P2:  return 2'b01;
        default: return 2'b00;
      endcase
      CMD_WRITE: case (p)
        P0, P3:  return {1'b1, ~b};
        default: return {1'b0, ~b};
      endcase
      default: case (p)
        P0, P3:  return 2'b10;
        default: return 2'b00;
      endcase
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
    end
  end

`ifdef DEV_I2C_PHY_STRETCH_EN
  // a slave holding SCL low while the high half is due swallows the tick
  assign adv = i_tick & (scl | ((state != P1) & (state != P2)));
`else
  logic unused_scl;
  assign unused_scl = scl;
  assign adv = i_tick;
`endif

  assign o_cmd_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    wbit_nxt      = wbit;
    scl_oe_nxt    = o_scl_oe;
    sda_oe_nxt    = o_sda_oe;
    rsp_valid_nxt = 1'b0;
    rsp_bit_nxt   = o_rsp_bit;
    rsp_arb_nxt   = o_rsp_arb;
    case (state)
      IDLE: if (i_cmd_valid) begin
        state_nxt = P0;
        cmd_nxt   = i_cmd;
        wbit_nxt  = i_cmd_bit;
        {scl_oe_nxt, sda_oe_nxt} = drive(i_cmd, i_cmd_bit, P0);
      end
      P0: if (adv) begin
        if (cmd == CMD_START && !sda) begin
          state_nxt = IDLE;
          {scl_oe_nxt, sda_oe_nxt} = 2'b00;
          rsp_valid_nxt = 1'b1;
          rsp_arb_nxt   = 1'b1;
        end else begin
          state_nxt = P1;
          {scl_oe_nxt, sda_oe_nxt} = drive(cmd, wbit, P1);
        end
      end
      P1: if (adv) begin
        state_nxt = P2;
        {scl_oe_nxt, sda_oe_nxt} = drive(cmd, wbit, P2);
      end
      P2: if (adv) begin
        rsp_bit_nxt = sda;
        if (cmd == CMD_WRITE && wbit && !sda) begin
          state_nxt = IDLE;
          {scl_oe_nxt, sda_oe_nxt} = 2'b00;
          rsp_valid_nxt = 1'b1;
          rsp_arb_nxt   = 1'b1;
        end else begin
          state_nxt = P3;
          {scl_oe_nxt, sda_oe_nxt} = drive(cmd, wbit, P3);
        end
      end
      P3: if (adv) begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_arb_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cmd         <= 2'b00;
      wbit        <= 1'b0;
      o_scl_oe    <= 1'b0;
      o_sda_oe    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_bit   <= 1'b0;
      o_rsp_arb   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd         <= cmd_nxt;
      wbit        <= wbit_nxt;
      o_scl_oe    <= scl_oe_nxt;
      o_sda_oe    <= sda_oe_nxt;
      o_rsp_valid <= rsp_valid_nxt;
      o_rsp_bit   <= rsp_bit_nxt;
      o_rsp_arb   <= rsp_arb_nxt;
    end
  end

endmodule

// File: tb/tb_dev_i2c_phy_bit.sv
// Directed bench for dev_i2c_phy_bit: open-drain bus model with wired-AND pull-ups and external overrides.
module tb_dev_i2c_phy_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic       cmd_bit = 1'b0;
  logic       rsp_valid, rsp_bit, rsp_arb;
  logic       scl, sda, scl_oe, sda_oe;
  logic       scl_ext = 1'b1;
  logic       sda_ext = 1'b1;
  int         tests = 0;
  int         fails = 0;

  assign scl = ~scl_oe & scl_ext;
  assign sda = ~sda_oe & sda_ext;

  always #5 clk = ~clk;

  dev_i2c_phy_bit dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd(cmd), .i_cmd_bit(cmd_bit),
    .o_rsp_valid(rsp_valid), .o_rsp_bit(rsp_bit), .o_rsp_arb(rsp_arb),
    .i_scl(scl), .i_sda(sda), .o_scl_oe(scl_oe), .o_sda_oe(sda_oe)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one quarter-bit: tick on the 4th cycle
  task automatic q();
    tick = 1'b0;
    step(); step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic b);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_bit = b;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_oe", {scl_oe, sda_oe}, 2'b00);
    chk("rst_ready", {1'b0, cmd_ready}, 2'b01);
    chk("rst_rsp", {rsp_valid, rsp_bit}, 2'b00);
    chk("rst_arb", {1'b0, rsp_arb}, 2'b00);
    rst = 1'b0;
    step();

    tick = 1'b1; step(); tick = 1'b0;
    chk("idle_tick_ready", {1'b0, cmd_ready}, 2'b01);
    chk("idle_tick_oe", {scl_oe, sda_oe}, 2'b00);

    // START
    issue(2'b00, 1'b0);
    chk("start_p0", {scl_oe, sda_oe}, 2'b00);
    chk("start_busy", {1'b0, cmd_ready}, 2'b00);
    q(); chk("start_p1", {scl_oe, sda_oe}, 2'b01);
    q(); chk("start_p2", {scl_oe, sda_oe}, 2'b01);
    q(); chk("start_p3", {scl_oe, sda_oe}, 2'b11);
    chk("start_no_rsp_early", {1'b0, rsp_valid}, 2'b00);
    q();
    chk("start_rsp", {rsp_valid, rsp_arb}, 2'b10);
    chk("start_ready", {1'b0, cmd_ready}, 2'b01);
    chk("start_hold", {scl_oe, sda_oe}, 2'b11);
    step();
    chk("start_rsp_1cyc", {1'b0, rsp_valid}, 2'b00);

    // WRITE 0, accepted with a coincident tick that must not advance P0
    cmd_valid = 1'b1; cmd = 2'b10; cmd_bit = 1'b0; tick = 1'b1;
    step();
    cmd_valid = 1'b0; tick = 1'b0;
    chk("w0_p0", {scl_oe, sda_oe}, 2'b11);
    q(); chk("w0_p1", {scl_oe, sda_oe}, 2'b01);
    q(); chk("w0_p2", {scl_oe, sda_oe}, 2'b01);
    q(); chk("w0_p3", {scl_oe, sda_oe}, 2'b11);
    q();
    chk("w0_rsp", {rsp_valid, rsp_bit}, 2'b10);
    chk("w0_arb", {1'b0, rsp_arb}, 2'b00);
    chk("w0_ready", {1'b0, cmd_ready}, 2'b01);
    // WRITE 1 back-to-back in the response cycle
    issue(2'b10, 1'b1);
    chk("w1_p0", {scl_oe, sda_oe}, 2'b10);
    chk("w1_busy", {cmd_ready, rsp_valid}, 2'b00);
    q(); chk("w1_p1", {scl_oe, sda_oe}, 2'b00);
    q(); q(); chk("w1_p3", {scl_oe, sda_oe}, 2'b10);
    q();
    chk("w1_rsp", {rsp_valid, rsp_bit}, 2'b11);
    chk("w1_arb", {1'b0, rsp_arb}, 2'b00);

    // READ, slave drives 0
    sda_ext = 1'b0;
    issue(2'b11, 1'b0);
    chk("r0_p0", {scl_oe, sda_oe}, 2'b10);
    q(); chk("r0_p1", {scl_oe, sda_oe}, 2'b00);
    q(); chk("r0_p2", {scl_oe, sda_oe}, 2'b00);
    q(); chk("r0_p3", {scl_oe, sda_oe}, 2'b10);
    q();
    chk("r0_rsp", {rsp_valid, rsp_bit}, 2'b10);
    chk("r0_arb", {1'b0, rsp_arb}, 2'b00);
    // READ, slave leaves 1
    sda_ext = 1'b1;
    issue(2'b11, 1'b0);
    q(); q(); q(); q();
    chk("r1_rsp", {rsp_valid, rsp_bit}, 2'b11);
    chk("r1_arb", {1'b0, rsp_arb}, 2'b00);

    // WRITE 1 loses arbitration after the 3rd tick
    sda_ext = 1'b0;
    issue(2'b10, 1'b1);
    q(); q();
    chk("warb_pre", {cmd_ready, rsp_valid}, 2'b00);
    q();
    chk("warb_rsp", {rsp_valid, rsp_arb}, 2'b11);
    chk("warb_oe", {scl_oe, sda_oe}, 2'b00);
    chk("warb_ready", {1'b0, cmd_ready}, 2'b01);
    step();
    chk("warb_1cyc", {1'b0, rsp_valid}, 2'b00);

    // START with SDA already low loses after the 1st tick
    issue(2'b00, 1'b0);
    q();
    chk("sarb_rsp", {rsp_valid, rsp_arb}, 2'b11);
    chk("sarb_oe", {scl_oe, sda_oe}, 2'b00);
    sda_ext = 1'b1;
    step(); step(); step();

    // READ with SCL held low by the slave during P1
    issue(2'b11, 1'b0);
    q();
    chk("str_p1", {scl_oe, sda_oe}, 2'b00);
    scl_ext = 1'b0;
`ifdef DEV_I2C_PHY_STRETCH_EN
    repeat (10) q();
    chk("str_frozen", {cmd_ready, rsp_valid}, 2'b00);
    chk("str_frozen_oe", {scl_oe, sda_oe}, 2'b00);
    scl_ext = 1'b1;
    q(); q();
    chk("str_not_yet", {1'b0, rsp_valid}, 2'b00);
    q();
    chk("str_rsp", {rsp_valid, rsp_bit}, 2'b11);
`else
    q(); q();
    chk("nostr_not_yet", {1'b0, rsp_valid}, 2'b00);
    q();
    chk("nostr_rsp", {rsp_valid, rsp_bit}, 2'b11);
    scl_ext = 1'b1;
`endif
    step();

    // reset during P2 of STOP
    issue(2'b01, 1'b0);
    chk("stop_p0", {scl_oe, sda_oe}, 2'b11);
    q(); q();
    chk("stop_p2", {scl_oe, sda_oe}, 2'b01);
    rst = 1'b1;
    step();
    chk("stop_rst_oe", {scl_oe, sda_oe}, 2'b00);
    chk("stop_rst_state", {cmd_ready, rsp_valid}, 2'b10);
    rst = 1'b0;
    q();
    chk("stop_rst_quiet", {cmd_ready, rsp_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
